// File: rtl/jtframe_sega_pkg.sv
// Shared constants and the phase-to-pin mapping for the Sega 6-button pad.
// The btn index constants are shared with the host-side reader.
package jtframe_sega_pkg;

    localparam int PAD_W = 6;
    localparam int BTN_W = 12;

    // TH phase counter values. Even phases are TH=1 and odd phases are TH=0.
    typedef logic [2:0] sega_ph_t;
    localparam sega_ph_t PH_IDLE  = 3'd0;
    localparam sega_ph_t PH_LO1   = 3'd1;
    localparam sega_ph_t PH_HI1   = 3'd2;
    localparam sega_ph_t PH_LO2   = 3'd3;
    localparam sega_ph_t PH_HI2   = 3'd4;
    localparam sega_ph_t PH_IDLO  = 3'd5;
    localparam sega_ph_t PH_EXTHI = 3'd6;
    localparam sega_ph_t PH_EXTLO = 3'd7;

    // Pad pin bit positions, named after their TH=1 meaning.
    // When TH=0, PAD_B carries A and PAD_C carries Start.
    localparam int PAD_UP    = 0;
    localparam int PAD_DOWN  = 1;
    localparam int PAD_LEFT  = 2;
    localparam int PAD_RIGHT = 3;
    localparam int PAD_B     = 4;
    localparam int PAD_C     = 5;

    // Button vector layout, pressed = 1.
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_START = 10;
    localparam int BTN_MODE  = 11;

    // Active-low pin image for a given phase. A 3-button pad folds phases
    // 5 and 7 onto the plain TH=0 image and phase 6 onto the plain TH=1 image.
    function automatic logic [PAD_W-1:0] sega_pad_map(
        input sega_ph_t         ph,
        input logic [BTN_W-1:0] btn,
        input logic             six_btn
    );
        sega_ph_t         eff;
        logic [PAD_W-1:0] pins;
        eff  = ph;
        pins = '1;
        if (!six_btn) begin
            if (ph == PH_IDLO || ph == PH_EXTLO) begin
                eff = PH_LO1;
            end else if (ph == PH_EXTHI) begin
                eff = PH_IDLE;
            end
        end
        case (eff)
            PH_IDLE, PH_HI1, PH_HI2: begin
                pins[PAD_C]     = ~btn[BTN_C];
                pins[PAD_B]     = ~btn[BTN_B];
                pins[PAD_RIGHT] = ~btn[BTN_RIGHT];
                pins[PAD_LEFT]  = ~btn[BTN_LEFT];
                pins[PAD_DOWN]  = ~btn[BTN_DOWN];
                pins[PAD_UP]    = ~btn[BTN_UP];
            end
            PH_LO1, PH_LO2: begin
                // Left/Right pins are forced low: that is how a host detects a pad.
                pins[PAD_C]     = ~btn[BTN_START];
                pins[PAD_B]     = ~btn[BTN_A];
                pins[PAD_RIGHT] = 1'b0;
                pins[PAD_LEFT]  = 1'b0;
                pins[PAD_DOWN]  = ~btn[BTN_DOWN];
                pins[PAD_UP]    = ~btn[BTN_UP];
            end
            PH_IDLO: begin
                // All four direction pins low identifies a 6-button pad.
                pins[PAD_C]     = ~btn[BTN_START];
                pins[PAD_B]     = ~btn[BTN_A];
                pins[PAD_RIGHT] = 1'b0;
                pins[PAD_LEFT]  = 1'b0;
                pins[PAD_DOWN]  = 1'b0;
                pins[PAD_UP]    = 1'b0;
            end
            PH_EXTHI: begin
                pins[PAD_C]     = ~btn[BTN_C];
                pins[PAD_B]     = ~btn[BTN_B];
                pins[PAD_RIGHT] = ~btn[BTN_MODE];
                pins[PAD_LEFT]  = ~btn[BTN_X];
                pins[PAD_DOWN]  = ~btn[BTN_Y];
                pins[PAD_UP]    = ~btn[BTN_Z];
            end
            PH_EXTLO: begin
                pins[PAD_C]     = ~btn[BTN_START];
                pins[PAD_B]     = ~btn[BTN_A];
                pins[PAD_RIGHT] = 1'b1;
                pins[PAD_LEFT]  = 1'b1;
                pins[PAD_DOWN]  = 1'b1;
                pins[PAD_UP]    = 1'b1;
            end
            default: pins = '1;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/jtframe_sega6_edge.sv
// Two-flop synchroniser for the host TH strobe, with a one-cycle pulse on
// either edge and the synchronised TH level.
module jtframe_sega6_edge
    import jtframe_sega_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_sel,
    output logic o_edge,
    output logic o_th
);

    logic [1:0] r_sync;
    logic       r_sync_d;

    // Resynchronise TH and keep one delayed copy for edge detection. Flops
    // reset high so an idle (high) TH produces no edge after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync   <= 2'b11;
            r_sync_d <= 1'b1;
        end else begin
            r_sync   <= {r_sync[0], i_sel};
            r_sync_d <= r_sync[1];
        end
    end

    assign o_edge = r_sync[1] ^ r_sync_d;
    assign o_th   = r_sync[1];

endmodule

// File: rtl/jtframe_sega6_pad.sv
// Device-side Mega Drive 6-button pad: tracks the host TH phase and drives
// the six active-low DB9 data pins from the joystick state.
module jtframe_sega6_pad
    import jtframe_sega_pkg::*;
#(
    parameter int CLK_KHZ    = 48000,
    parameter int TIMEOUT_US = 1500,
    parameter int SIX_BTN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [BTN_W-1:0] btn,
    output logic [PAD_W-1:0] pad,
    output logic             six_rd
);

    localparam int              TMAX   = CLK_KHZ * TIMEOUT_US / 1000;
    localparam int              TW     = $clog2(TMAX + 1);
    localparam logic [TW-1:0]   TMAX_V = TW'(TMAX);
    localparam logic            SIX_EN = (SIX_BTN != 0);

    logic             w_edge;
    logic             w_th;
    logic             w_tmax;
    logic [TW-1:0]    r_timer;
    logic [TW-1:0]    w_timer_next;
    sega_ph_t         r_ph;
    sega_ph_t         w_ph_next;
    logic [PAD_W-1:0] r_pad;
    logic             r_six_rd;

    jtframe_sega6_edge u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sel  (sel),
        .o_edge (w_edge),
        .o_th   (w_th)
    );

    assign w_tmax = (r_timer == TMAX_V);

    // Next phase and idle timer. A TH edge always advances the phase, even on
    // the cycle the timer saturates; a saturated timer re-arms the phase to
    // the start of a read sequence while keeping parity with the TH level.
    always_comb begin
        w_ph_next    = r_ph;
        w_timer_next = r_timer;
        if (w_edge) begin
            w_ph_next    = r_ph + 3'd1;
            w_timer_next = '0;
        end else if (w_tmax) begin
            w_ph_next    = {2'b00, ~w_th};
        end else begin
            w_timer_next = r_timer + 1'b1;
        end
    end

    // Phase/timer state and registered outputs. The pin image is built from
    // the next phase so a TH edge shows on the pins one cycle after detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_timer  <= '0;
            r_ph     <= PH_IDLE;
            r_pad    <= '1;
            r_six_rd <= 1'b0;
        end else begin
            r_timer  <= w_timer_next;
            r_ph     <= w_ph_next;
            r_pad    <= sega_pad_map(w_ph_next, btn, SIX_EN);
            r_six_rd <= SIX_EN && (w_ph_next == PH_EXTHI) && (r_ph != PH_EXTHI);
        end
    end

    assign pad    = r_pad;
    assign six_rd = r_six_rd;

endmodule
